// File: rtl/mfm_record_parser.sv
`default_nettype none
// ============================================================================
//  Module      : mfm_record_parser
//  Description : Byte-level MFM record parser for ID (FE) and data (FB/F8) records,
//                with CRC-CCITT checking and a data-acceptance window after each good ID.
//  Revision    : 1.0  initial release
// ============================================================================
module mfm_record_parser #(
    parameter int          SYNC_COUNT    = 3,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA1,
    parameter int          MAX_SIZE_CODE = 3,
    parameter int          GAP_LIMIT     = 64,
    parameter int          IW            = 7 + MAX_SIZE_CODE
) (
    input  logic          i_Clk,
    input  logic          i_Reset_n,
    input  logic          i_Sync,
    input  logic [7:0]    i_Data,
    input  logic          i_Valid,
    output logic [7:0]    o_Track,
    output logic [7:0]    o_Side,
    output logic [7:0]    o_Sector,
    output logic [7:0]    o_SizeCode,
    output logic          o_HeaderValid,
    output logic          o_HeaderCRCError,
    output logic [7:0]    o_DataByte,
    output logic          o_DataValid,
    output logic [IW-1:0] o_DataIndex,
    output logic          o_Deleted,
    output logic          o_DataDone,
    output logic          o_DataCRCError,
    output logic          o_Orphan,
    output logic          o_Abort,
    output logic [3:0]    o_State
);

    localparam int          GW          = $clog2(GAP_LIMIT + 2);
    localparam logic [GW-1:0] c_GapLimit = GW'(GAP_LIMIT);
    localparam logic [GW-1:0] c_GapSat   = GW'(GAP_LIMIT + 1);
    localparam logic [2:0]  c_SyncLast  = 3'(SYNC_COUNT - 1);
    localparam logic [7:0]  c_MaxCode   = 8'(MAX_SIZE_CODE);
    localparam logic [7:0]  c_MarkId    = 8'hFE;
    localparam logic [7:0]  c_MarkData  = 8'hFB;
    localparam logic [7:0]  c_MarkDel   = 8'hF8;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_SYNC       = 4'd1,
        S_MARK       = 4'd2,
        S_ID_FIELD   = 4'd3,
        S_ID_CRC     = 4'd4,
        S_ID_CHECK   = 4'd5,
        S_DATA_FIELD = 4'd6,
        S_DATA_CRC   = 4'd7,
        S_DATA_CHECK = 4'd8
    } state_t;

    state_t          r_State;
    logic [2:0]      r_SyncCnt;
    logic [15:0]     r_Crc;
    logic [15:0]     r_CrcRx;
    logic [IW-1:0]   r_Cnt;
    logic [7:0]      r_ShTrack, r_ShSide, r_ShSector, r_ShSize;
    logic [GW-1:0]   r_GapCnt;
    logic            r_WinOpen;

    logic [15:0]     w_CrcNext;
    logic            w_WinOk;
    logic            w_SizeOk;
    logic            w_InField;
    logic [IW-1:0]   w_LastIdx;

    // Bit-serial CCITT update, MSB of the data byte first.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] v;
        v = c;
        for (int i = 7; i >= 0; i--) begin
            if (v[15] ^ d[i]) v = {v[14:0], 1'b0} ^ 16'h1021;
            else              v = {v[14:0], 1'b0};
        end
        return v;
    endfunction

    assign w_CrcNext = crc_byte(r_Crc, i_Data);
    assign w_WinOk   = r_WinOpen && (r_GapCnt <= c_GapLimit);
    assign w_SizeOk  = (o_SizeCode <= c_MaxCode);
    assign w_LastIdx = IW'((32'd128 << o_SizeCode) - 32'd1);
    assign w_InField = (r_State == S_ID_FIELD) || (r_State == S_ID_CRC) ||
                       (r_State == S_DATA_FIELD) || (r_State == S_DATA_CRC);
    assign o_State   = r_State;

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            r_State          <= S_IDLE;
            r_SyncCnt        <= '0;
            r_Crc            <= '0;
            r_CrcRx          <= '0;
            r_Cnt            <= '0;
            r_ShTrack        <= '0;
            r_ShSide         <= '0;
            r_ShSector       <= '0;
            r_ShSize         <= '0;
            r_GapCnt         <= '0;
            r_WinOpen        <= 1'b0;
            o_Track          <= '0;
            o_Side           <= '0;
            o_Sector         <= '0;
            o_SizeCode       <= '0;
            o_HeaderValid    <= 1'b0;
            o_HeaderCRCError <= 1'b0;
            o_DataByte       <= '0;
            o_DataValid      <= 1'b0;
            o_DataIndex      <= '0;
            o_Deleted        <= 1'b0;
            o_DataDone       <= 1'b0;
            o_DataCRCError   <= 1'b0;
            o_Orphan         <= 1'b0;
            o_Abort          <= 1'b0;
        end else begin
            o_HeaderValid    <= 1'b0;
            o_HeaderCRCError <= 1'b0;
            o_DataValid      <= 1'b0;
            o_DataDone       <= 1'b0;
            o_DataCRCError   <= 1'b0;
            o_Orphan         <= 1'b0;
            o_Abort          <= 1'b0;

            // Gap counter saturates one past the limit, which keeps the window shut.
            if (i_Valid && r_WinOpen && (r_GapCnt != c_GapSat))
                r_GapCnt <= r_GapCnt + 1'b1;

            if (i_Sync && (r_State != S_SYNC)) begin
                r_State   <= S_SYNC;
                r_SyncCnt <= '0;
                r_Crc     <= 16'hFFFF;
                o_Abort   <= w_InField;
            end else begin
                case (r_State)
                    S_SYNC: if (i_Valid) begin
                        if (i_Data == SYNC_BYTE) begin
                            r_Crc <= w_CrcNext;
                            if (r_SyncCnt == c_SyncLast) r_State <= S_MARK;
                            else                         r_SyncCnt <= r_SyncCnt + 3'd1;
                        end else begin
                            r_State <= S_IDLE;
                        end
                    end
                    S_MARK: if (i_Valid) begin
                        r_Crc <= w_CrcNext;
                        r_Cnt <= '0;
                        if (i_Data == c_MarkId) begin
                            r_State <= S_ID_FIELD;
                        end else if ((i_Data == c_MarkData) || (i_Data == c_MarkDel)) begin
                            if (w_WinOk && w_SizeOk) begin
                                r_State   <= S_DATA_FIELD;
                                o_Deleted <= (i_Data == c_MarkDel);
                                r_WinOpen <= 1'b0;
                            end else begin
                                o_Orphan <= 1'b1;
                                r_State  <= S_IDLE;
                            end
                        end else begin
                            r_State <= S_IDLE;
                        end
                    end
                    S_ID_FIELD: if (i_Valid) begin
                        r_Crc <= w_CrcNext;
                        case (r_Cnt[1:0])
                            2'd0:    r_ShTrack  <= i_Data;
                            2'd1:    r_ShSide   <= i_Data;
                            2'd2:    r_ShSector <= i_Data;
                            default: r_ShSize   <= i_Data;
                        endcase
                        if (r_Cnt[1:0] == 2'd3) begin
                            r_State <= S_ID_CRC;
                            r_Cnt   <= '0;
                        end else begin
                            r_Cnt <= r_Cnt + 1'b1;
                        end
                    end
                    S_ID_CRC: if (i_Valid) begin
                        r_CrcRx <= {r_CrcRx[7:0], i_Data};
                        if (r_Cnt[0]) r_State <= S_ID_CHECK;
                        else          r_Cnt   <= r_Cnt + 1'b1;
                    end
                    S_ID_CHECK: begin
                        if (r_CrcRx == r_Crc) begin
                            o_Track       <= r_ShTrack;
                            o_Side        <= r_ShSide;
                            o_Sector      <= r_ShSector;
                            o_SizeCode    <= r_ShSize;
                            o_HeaderValid <= 1'b1;
                            r_WinOpen     <= 1'b1;
                            r_GapCnt      <= '0;
                        end else begin
                            o_HeaderCRCError <= 1'b1;
                            r_WinOpen        <= 1'b0;
                        end
                        r_State <= S_IDLE;
                    end
                    S_DATA_FIELD: if (i_Valid) begin
                        r_Crc       <= w_CrcNext;
                        o_DataByte  <= i_Data;
                        o_DataIndex <= r_Cnt;
                        o_DataValid <= 1'b1;
                        if (r_Cnt == w_LastIdx) begin
                            r_State <= S_DATA_CRC;
                            r_Cnt   <= '0;
                        end else begin
                            r_Cnt <= r_Cnt + 1'b1;
                        end
                    end
                    S_DATA_CRC: if (i_Valid) begin
                        r_CrcRx <= {r_CrcRx[7:0], i_Data};
                        if (r_Cnt[0]) r_State <= S_DATA_CHECK;
                        else          r_Cnt   <= r_Cnt + 1'b1;
                    end
                    S_DATA_CHECK: begin
                        if (r_CrcRx == r_Crc) o_DataDone     <= 1'b1;
                        else                  o_DataCRCError <= 1'b1;
                        r_State <= S_IDLE;
                    end
                    default: r_State <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
